// File: rtl/sha1_msg_pad_if.sv
// sha1_msg_pad_if: signal bundle of the SHA-1 padding front end.
// Carries the message word stream, the compression-core handshake and the digest.
// master = message source plus compression core, slave = the padder itself.
interface sha1_msg_pad_if;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_word;
  logic         i_last;
  logic [2:0]   i_bytes;
  logic         o_start;
  logic [511:0] o_data;
  logic [159:0] o_vin;
  logic         i_core_done;
  logic [159:0] i_core_vout;
  logic [159:0] o_digest;
  logic         o_digest_valid;

  modport master (
    output i_valid, i_word, i_last, i_bytes, i_core_done, i_core_vout,
    input  o_ready, o_start, o_data, o_vin, o_digest, o_digest_valid
  );

  modport slave (
    input  i_valid, i_word, i_last, i_bytes, i_core_done, i_core_vout,
    output o_ready, o_start, o_data, o_vin, o_digest, o_digest_valid
  );
endinterface

// File: rtl/sha1_msg_pad.sv
// sha1_msg_pad: FIPS 180-4 message padding and 512-bit block sequencing in
// front of a SHA-1 compression core. Chains each block result into the next
// block's o_vin and presents the digest after the final block.
// Optional feature macro: SHA1_PAD_BYTE_EN -- when defined, i_bytes selects
// how many left-justified bytes of the last word are message data (0..4).
module sha1_msg_pad #(
  parameter logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sha1_msg_pad_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAD   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t       state;
  logic [31:0]  blk [16];      // block under construction, also drives o_data
  logic [4:0]   idx;           // next word slot in LOAD
  logic [4:0]   fill_idx;      // first word slot PAD zero-fills (16 = none)
  logic         mark_next;     // 0x80 still owed at the start of word fill_idx
  logic         extra;         // one more pure padding block follows this one
  logic         extra_mark;    // that padding block starts with the 0x80 byte
  logic         last_seen;     // final message word already taken
  logic [63:0]  len;           // message length in bits, wraps mod 2^64
  logic         ready;
  logic         start;
  logic [159:0] vin;
  logic [159:0] digest;
  logic         digest_valid;

  logic         accept;
  logic [2:0]   nbytes;
  logic [31:0]  last_word;
  logic         fits;
  logic [511:0] data_pack;

  assign accept = bus.i_valid & ready;

`ifdef SHA1_PAD_BYTE_EN
  // Number of message bytes in the last word, clamped to a full word.
  always_comb begin
    if (bus.i_bytes > 3'd4) begin
      nbytes = 3'd4;
    end else begin
      nbytes = bus.i_bytes;
    end
  end
`else
  logic unused_bytes;
  assign nbytes       = 3'd4;
  assign unused_bytes = ^bus.i_bytes;
`endif

  // Last word with trailing bytes cleared and the 0x80 marker after the data.
  always_comb begin
    case (nbytes)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.i_word[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.i_word[31:16], 16'h8000};
      3'd3:    last_word = {bus.i_word[31:8], 8'h80};
      default: last_word = bus.i_word;
    endcase
  end

  // Length fits in words 14/15 when data plus marker occupy at most 56 bytes.
  always_comb begin
    if (mark_next) begin
      fits = (fill_idx <= 5'd13);
    end else begin
      fits = (fill_idx <= 5'd14);
    end
  end

  // Flatten the word buffer, word 0 in the most significant position.
  always_comb begin
    data_pack = 512'd0;
    for (int g = 0; g < 16; g++) begin
      data_pack[511 - 32*g -: 32] = blk[g];
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_start        = start;
  assign bus.o_data         = data_pack;
  assign bus.o_vin          = vin;
  assign bus.o_digest       = digest;
  assign bus.o_digest_valid = digest_valid;

  // Padding / block sequencing state machine with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      idx          <= 5'd0;
      fill_idx     <= 5'd0;
      mark_next    <= 1'b0;
      extra        <= 1'b0;
      extra_mark   <= 1'b0;
      last_seen    <= 1'b0;
      len          <= 64'd0;
      ready        <= 1'b0;
      start        <= 1'b0;
      vin          <= IV;
      digest       <= 160'd0;
      digest_valid <= 1'b0;
      for (int w = 0; w < 16; w++) begin
        blk[w] <= 32'd0;
      end
    end else begin
      start        <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          vin        <= IV;
          len        <= 64'd0;
          idx        <= 5'd0;
          last_seen  <= 1'b0;
          extra      <= 1'b0;
          extra_mark <= 1'b0;
          mark_next  <= 1'b0;
          ready      <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            digest <= 160'd0;
            if (bus.i_last) begin
              blk[idx[3:0]] <= last_word;
              len           <= len + {58'd0, nbytes, 3'd0};
              fill_idx      <= idx + 5'd1;
              mark_next     <= (nbytes == 3'd4);
              last_seen     <= 1'b1;
              ready         <= 1'b0;
              state         <= PAD;
            end else begin
              blk[idx[3:0]] <= bus.i_word;
              len           <= len + 64'd32;
              if (idx == 5'd15) begin
                idx   <= 5'd0;
                ready <= 1'b0;
                start <= 1'b1;
                state <= START;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
        end
        PAD: begin
          for (int w = 0; w < 16; w++) begin
            if (5'(w) >= fill_idx) begin
              if (mark_next && (5'(w) == fill_idx)) begin
                blk[w] <= 32'h8000_0000;
              end else begin
                blk[w] <= 32'd0;
              end
            end
          end
          if (fits) begin
            blk[14] <= len[63:32];
            blk[15] <= len[31:0];
          end
          extra      <= ~fits;
          extra_mark <= mark_next & (fill_idx == 5'd16);
          start      <= 1'b1;
          state      <= START;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.i_core_done) begin
            vin <= bus.i_core_vout;
            idx <= 5'd0;
            if (!last_seen) begin
              ready <= 1'b1;
              state <= LOAD;
            end else if (extra) begin
              fill_idx  <= 5'd0;
              mark_next <= extra_mark;
              extra     <= 1'b0;
              state     <= PAD;
            end else begin
              digest       <= bus.i_core_vout;
              digest_valid <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_pad.sv
// tb_sha1_msg_pad: randomized self-checking bench for sha1_msg_pad.
// A byte-level padding model predicts every block, chaining value and digest;
// a behavioural SHA-1 compression function plays the role of the core.
module tb_sha1_msg_pad;

  localparam logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

  logic clk;
  logic rst;
  sha1_msg_pad_if bus ();

  sha1_msg_pad dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  logic [7:0]   msg_q [$];
  logic [511:0] exp_blk_q [$];
  logic [159:0] exp_vin_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d); k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d; k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d; k = 32'hCA62C1D6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  task automatic set_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // Compression core stand-in: checks each block, holds it a random time, answers.
  initial begin : core_model
    logic [511:0] cap_d;
    logic [159:0] cap_v;
    int dly;
    bus.i_core_done = 1'b0;
    bus.i_core_vout = 160'd0;
    forever begin
      @(posedge clk); #1;
      bus.i_core_done = 1'b0;
      if (bus.o_start === 1'b1) begin
        starts++;
        if (exp_blk_q.size() == 0) begin
          check_eq("stray_start", 32'(exp_blk_q.size()), 32'd1);
          cap_d = bus.o_data;
          cap_v = bus.o_vin;
        end else begin
          cap_d = exp_blk_q.pop_front();
          cap_v = exp_vin_q.pop_front();
          check_eq("block_data", bus.o_data, cap_d);
          check_eq("block_vin", bus.o_vin, cap_v);
        end
        dly = $urandom_range(1, 5);
        for (int c = 0; c < dly; c++) begin
          @(posedge clk); #1;
          check_eq("wait_data_stable", bus.o_data, cap_d);
          check_eq("wait_vin_stable", bus.o_vin, cap_v);
          check_eq("no_start_in_wait", bus.o_start, 1'b0);
        end
        bus.i_core_done = 1'b1;
        bus.i_core_vout = sha1_compress(cap_v, cap_d);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.i_core_done = 1'b1;
        bus.i_core_vout = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Send msg_q through the DUT and check blocks, digest and the return to idle.
  task automatic run_msg(input bit toggle, input logic [159:0] known, input bit use_known);
    logic [7:0]   p [$];
    logic [63:0]  bitlen;
    logic [511:0] b;
    logic [159:0] h;
    logic [31:0]  wd;
    int n, nwords, nblk, i, cyc, s0, nb;
    bit fed, first;
    n = msg_q.size();
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    nblk = p.size() / 64;
    h = IV;
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
      exp_blk_q.push_back(b);
      exp_vin_q.push_back(h);
      h = sha1_compress(h, b);
    end
    s0 = starts;
    nwords = (n == 0) ? 1 : (n + 3) / 4;
    i = 0; cyc = 0; first = 1'b1;
    while (i < nwords && cyc < 4000) begin
      fed = 1'b0;
      if (!toggle || $urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 4; j++) begin
          if (4*i + j < n) wd[31 - 8*j -: 8] = msg_q[4*i + j];
          else             wd[31 - 8*j -: 8] = 8'($urandom);
        end
        nb = n - 4*i;
        if (nb > 4) nb = 4;
        bus.i_valid = 1'b1;
        bus.i_word  = wd;
        bus.i_last  = (i == nwords - 1);
        bus.i_bytes = 3'(nb);
        fed = bus.o_ready;
      end else begin
        bus.i_valid = 1'b0;
        bus.i_word  = $urandom;
        bus.i_last  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (fed) begin
        i++;
        if (first) begin
          check_eq("digest_clear_on_first_word", bus.o_digest, 160'd0);
          first = 1'b0;
        end
      end
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check_eq("feed_timeout", i, nwords);
    cyc = 0;
    while (bus.o_digest_valid !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("digest_valid_seen", bus.o_digest_valid, 1'b1);
    check_eq("digest", bus.o_digest, h);
    if (use_known) check_eq("digest_known", bus.o_digest, known);
    check_eq("block_count", starts - s0, nblk);
    @(posedge clk); #1;
    check_eq("digest_valid_pulse", bus.o_digest_valid, 1'b0);
    check_eq("digest_hold", bus.o_digest, h);
    check_eq("vin_reload_iv", bus.o_vin, IV);
    check_eq("ready_after_idle", bus.o_ready, 1'b1);
    exp_blk_q.delete();
    exp_vin_q.delete();
  endtask

  initial begin : main
    int i, cyc, cnt, n;
    bit fed;
    string s56;
    logic [159:0] d56;
`ifdef SHA1_PAD_BYTE_EN
    int blens [8] = '{55, 56, 57, 63, 64, 65, 119, 120};
`else
    int blens [8] = '{52, 56, 60, 64, 68, 116, 120, 128};
`endif
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    d56 = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_word  = 32'd0;
    bus.i_last  = 1'b0;
    bus.i_bytes = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", bus.o_ready, 1'b0);
    check_eq("rst_start", bus.o_start, 1'b0);
    check_eq("rst_data", bus.o_data, 512'd0);
    check_eq("rst_vin", bus.o_vin, IV);
    check_eq("rst_digest", bus.o_digest, 160'd0);
    check_eq("rst_digest_valid", bus.o_digest_valid, 1'b0);
    rst = 1'b0;

`ifdef SHA1_PAD_BYTE_EN
    set_str("abc");
    run_msg(1'b0, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);
    msg_q.delete();
    run_msg(1'b0, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1'b1);
`endif
    set_str(s56);
    run_msg(1'b0, d56, 1'b1);

    msg_q.delete();
    for (int k = 0; k < 64; k++) msg_q.push_back(8'h61);
    run_msg(1'b1, 160'd0, 1'b0);

    // partial message, then reset while loading
    i = 0; cyc = 0;
    bus.i_last = 1'b0;
    while (i < 7 && cyc < 200) begin
      bus.i_valid = 1'b1;
      bus.i_word  = $urandom;
      fed = bus.o_ready;
      @(posedge clk); #1;
      if (fed) i++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_ready", bus.o_ready, 1'b0);
    check_eq("midrst_vin", bus.o_vin, IV);
    check_eq("midrst_digest", bus.o_digest, 160'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.o_start === 1'b1 || bus.o_digest_valid === 1'b1) cnt++;
    end
    check_eq("no_stray_pulse", cnt, 0);
`ifdef SHA1_PAD_BYTE_EN
    set_str("abc");
    run_msg(1'b0, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);
    run_msg(1'b0, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);
`else
    set_str(s56);
    run_msg(1'b0, d56, 1'b1);
    run_msg(1'b0, d56, 1'b1);
`endif

    foreach (blens[k]) begin
      msg_q.delete();
      for (int j = 0; j < blens[k]; j++) msg_q.push_back(8'($urandom));
      run_msg(1'($urandom_range(0, 1)), 160'd0, 1'b0);
    end

    for (int m = 0; m < 8; m++) begin
`ifdef SHA1_PAD_BYTE_EN
      n = $urandom_range(0, 140);
`else
      n = 4 * $urandom_range(1, 35);
`endif
      msg_q.delete();
      for (int j = 0; j < n; j++) msg_q.push_back(8'($urandom));
      run_msg(1'($urandom_range(0, 1)), 160'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
